// File: rtl/layer1_pool_window_pkg.sv
// Shared constants for the layer-1 window generator and the max-pool stage it feeds.
// Both blocks use the same window lane layout.
package layer1_pool_window_pkg;

  // Lane index of each activation inside one channel's 4-lane window word.
  localparam int unsigned lane_tl   = 0;
  localparam int unsigned lane_tr   = 1;
  localparam int unsigned lane_bl   = 2;
  localparam int unsigned lane_br   = 3;
  localparam int unsigned lane_num  = 4;

  localparam int unsigned lane_bits = 16;
  localparam int unsigned win_bits  = lane_num * lane_bits;

  typedef enum logic [0:0] {
    StTop,
    StBottom
  } pool_state_e;

endpackage

// File: rtl/layer1_pool_window_if.sv
// Pixel-in / window-out bus between conv1, the window generator and the pool stage.
interface layer1_pool_window_if #(
  parameter int unsigned bits        = 16,
  parameter int unsigned channel_num = 16
);
  import layer1_pool_window_pkg::*;

  logic                               frame_sync;
  logic [channel_num*bits-1:0]        pix_in;
  logic                               pix_valid;
  logic [channel_num*lane_num*bits-1:0] win_out;
  logic                               start;
  logic                               frame_done;

  modport master (
    output frame_sync, pix_in, pix_valid,
    input  win_out, start, frame_done
  );

  modport slave (
    input  frame_sync, pix_in, pix_valid,
    output win_out, start, frame_done
  );

endinterface

// File: rtl/layer1_line_buffer.sv
// One-row pixel store: synchronous write, combinational read.
// Storage is unreset; contents are only read after being written in the same frame.
module layer1_line_buffer #(
  parameter int unsigned depth     = 28,
  parameter int unsigned width     = 256,
  parameter int unsigned addr_bits = 5
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [addr_bits-1:0] waddr_i,
  input  logic [width-1:0]     wdata_i,
  input  logic [addr_bits-1:0] raddr_i,
  output logic [width-1:0]     rdata_o
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer1_pool_window.sv
// Raster-order pixel stream to non-overlapping 2x2 windows (stride 2) for the layer-1 max-pool.
// Even rows go to the line buffer; odd rows pair with it to form windows.
module layer1_pool_window
  import layer1_pool_window_pkg::*;
#(
  parameter int unsigned bits        = lane_bits,
  parameter int unsigned bits_shift  = 4,
  parameter int unsigned channel_num = 16,
  parameter int unsigned img_width   = 28,
  parameter int unsigned img_height  = 28,
  parameter int unsigned col_bits    = 5,
  parameter int unsigned row_bits    = 5
) (
  input logic                 clk_in,
  input logic                 rst_n,
  layer1_pool_window_if.slave bus
);

  localparam int unsigned pix_w = channel_num * bits;
  localparam int unsigned win_w = channel_num * lane_num * bits;

  localparam logic [col_bits-1:0] last_col     = col_bits'(img_width - 1);
  localparam logic [row_bits-1:0] last_row     = row_bits'(img_height - 1);
  localparam logic [col_bits-1:0] last_win_col = col_bits'((img_width / 2) * 2 - 1);
  localparam logic [row_bits-1:0] last_win_row = row_bits'((img_height / 2) * 2 - 1);

  pool_state_e         state_q;
  logic [col_bits-1:0] col_q;
  logic [row_bits-1:0] row_q;
  logic [pix_w-1:0]    tl_hold_q;
  logic [pix_w-1:0]    bl_hold_q;
  logic [win_w-1:0]    win_q;
  logic                start_q;
  logic                frame_done_q;

  pool_state_e         state_eff;
  logic [col_bits-1:0] col_eff;
  logic [row_bits-1:0] row_eff;
  logic                col_wrap;
  logic                row_wrap;
  logic                lb_we;
  logic [pix_w-1:0]    lb_rdata;
  logic [win_w-1:0]    win_d;

  // frame_sync makes the current pixel (0,0) of a fresh frame, dropping any partial window.
  always_comb begin
    state_eff = bus.frame_sync ? StTop : state_q;
    col_eff   = bus.frame_sync ? '0 : col_q;
    row_eff   = bus.frame_sync ? '0 : row_q;
  end

  assign col_wrap = bus.pix_valid && (col_eff == last_col);
  assign row_wrap = col_wrap && (row_eff == last_row);
  assign lb_we    = bus.pix_valid && (state_eff == StTop);

  layer1_line_buffer #(
    .depth     (img_width),
    .width     (pix_w),
    .addr_bits (col_bits)
  ) u_line_buf (
    .clk_i   (clk_in),
    .we_i    (lb_we),
    .waddr_i (col_eff),
    .wdata_i (bus.pix_in),
    .raddr_i (col_eff),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    win_d = '0;
    for (int c = 0; c < channel_num; c++) begin
      win_d[((c * lane_num + lane_tl) << bits_shift) +: bits] = tl_hold_q[(c << bits_shift) +: bits];
      win_d[((c * lane_num + lane_tr) << bits_shift) +: bits] = lb_rdata[(c << bits_shift) +: bits];
      win_d[((c * lane_num + lane_bl) << bits_shift) +: bits] = bl_hold_q[(c << bits_shift) +: bits];
      win_d[((c * lane_num + lane_br) << bits_shift) +: bits] = bus.pix_in[(c << bits_shift) +: bits];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StTop;
      col_q        <= '0;
      row_q        <= '0;
      tl_hold_q    <= '0;
      bl_hold_q    <= '0;
      win_q        <= '0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.pix_valid) begin
        col_q <= col_wrap ? '0 : col_eff + 1'b1;
        if (col_wrap) begin
          row_q   <= row_wrap ? '0 : row_eff + 1'b1;
          // An odd final row is consumed in StTop, so a frame wrap always lands in StTop.
          state_q <= (row_wrap || state_eff == StBottom) ? StTop : StBottom;
        end else begin
          row_q   <= row_eff;
          state_q <= state_eff;
        end
        if (state_eff == StBottom) begin
          if (!col_eff[0]) begin
            bl_hold_q <= bus.pix_in;
            tl_hold_q <= lb_rdata;
          end else begin
            win_q        <= win_d;
            start_q      <= 1'b1;
            frame_done_q <= (row_eff == last_win_row) && (col_eff == last_win_col);
          end
        end
      end else if (bus.frame_sync) begin
        col_q   <= '0;
        row_q   <= '0;
        state_q <= StTop;
      end
    end
  end

  assign bus.win_out    = win_q;
  assign bus.start      = start_q;
  assign bus.frame_done = frame_done_q;

endmodule
